// File: rtl/rr_grant_arbiter_pkg.sv
// arb_pkg: shared FSM state type and counter sizing for rr_grant_arbiter
package arb_pkg;
    typedef enum logic {IDLE, BUSY} state_t;
    function automatic int cnt_width(input int max_hold);
        return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
    endfunction
endpackage

// File: rtl/rr_grant_arbiter_if.sv
// rr_grant_arbiter_if: request/release/grant bundle between requesters and the arbiter
interface rr_grant_arbiter_if #(parameter int N = 4);
    localparam int IW = $clog2(N);
    logic [N-1:0]  req;
    logic [N-1:0]  done;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_vld;
    logic          timeout;
    modport master (output req, done, input gnt, gnt_idx, gnt_vld, timeout);
    modport slave (input req, done, output gnt, gnt_idx, gnt_vld, timeout);
endinterface

// File: rtl/rr_grant_arbiter_ff_lsb_encoder.sv
// ff_lsb_encoder: index of the lowest set bit of vec, with an any-set flag
module ff_lsb_encoder #(parameter int N = 4) (
    input  logic [N-1:0]         vec,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    always_comb begin
        idx = '0;
        any = |vec;
        for (int i = N - 1; i >= 0; i--)
            if (vec[i]) idx = ($clog2(N))'(i);
    end
endmodule

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter with owner release and hold timeout
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int N = 4,
    parameter int MAX_HOLD = 16
) (
    input logic               clk,
    input logic               rstb,
    rr_grant_arbiter_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int CW = cnt_width(MAX_HOLD);
    state_t        state;
    logic [IW-1:0] ptr;
    logic [CW-1:0] hold_cnt;
    logic [N-1:0]  masked;
    logic [IW-1:0] m_idx, r_idx, sel;
    logic          m_any, r_any, own_done, own_drop, expire;
    always_comb begin
        masked = '0;
        for (int i = 0; i < N; i++) masked[i] = bus.req[i] && (i > int'(ptr));
    end
    ff_lsb_encoder #(.N(N)) u_masked (.vec(masked), .idx(m_idx), .any(m_any));
    ff_lsb_encoder #(.N(N)) u_raw (.vec(bus.req), .idx(r_idx), .any(r_any));
    assign sel      = m_any ? m_idx : r_idx;
    assign own_done = bus.done[bus.gnt_idx];
    assign own_drop = !bus.req[bus.gnt_idx];
    assign expire   = (MAX_HOLD != 0) && (hold_cnt == CW'(MAX_HOLD - 1));
    // timeout flags only an exit forced purely by the hold limit
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state       <= IDLE;
            ptr         <= IW'(N - 1);
            hold_cnt    <= '0;
            bus.gnt     <= '0;
            bus.gnt_idx <= '0;
            bus.gnt_vld <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            bus.timeout <= 1'b0;
            if (state == IDLE) begin
                if (r_any) begin
                    state       <= BUSY;
                    bus.gnt     <= N'(1) << sel;
                    bus.gnt_idx <= sel;
                    bus.gnt_vld <= 1'b1;
                    ptr         <= sel;
                    hold_cnt    <= '0;
                end
            end else if (own_done || own_drop || expire) begin
                state       <= IDLE;
                bus.gnt     <= '0;
                bus.gnt_idx <= '0;
                bus.gnt_vld <= 1'b0;
                bus.timeout <= !own_done && !own_drop;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: directed and random checks against a cycle-level ownership model
module tb_rr_grant_arbiter;
    localparam int N = 4;
    localparam int MAX_HOLD = 4;
    logic clk = 1'b0;
    logic rstb = 1'b0;
    int errors = 0;
    int checks = 0;
    int owner = -1;
    int mptr = N - 1;
    int held = 0;
    bit to_p = 1'b0;

    rr_grant_arbiter_if #(.N(N)) bus ();
    rr_grant_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .rstb(rstb), .bus(bus));

    always #5 clk = ~clk;

    wire [N+3:0] got = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.timeout};

    function automatic logic [N+3:0] expv();
        logic [N-1:0] g;
        logic [1:0] ix;
        g = (owner >= 0) ? N'(1) << owner : '0;
        ix = (owner >= 0) ? 2'(owner) : 2'd0;
        return {g, ix, owner >= 0, to_p};
    endfunction

    // Model: owner is who holds the resource, held counts cycles of ownership so far.
    task automatic tick(input logic [N-1:0] rq, input logic [N-1:0] dn, input logic rb);
        bus.req = rq;
        bus.done = dn;
        rstb = rb;
        @(posedge clk);
        to_p = 1'b0;
        if (!rb) begin
            owner = -1;
            mptr = N - 1;
            held = 0;
        end else if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (mptr + k) % N;
                if (rq[c]) begin
                    owner = c;
                    mptr = c;
                    held = 1;
                    break;
                end
            end
        end else if (dn[owner] || !rq[owner] || held == MAX_HOLD) begin
            to_p = !dn[owner] && rq[owner];
            owner = -1;
        end else begin
            held++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(4'b1111, 4'b0000, 1'b0);
        tick(4'b1111, 4'b0000, 1'b0);
        checks++;
        if (got !== '0) begin errors++; $display("FAIL reset_state: got=%h exp=0", got); end
        tick(4'b1111, 4'b0000, 1'b1);
        checks++;
        if (bus.gnt !== 4'b0001 || bus.gnt_idx !== 2'd0) begin errors++; $display("FAIL first_grant: gnt=%b idx=%0d exp 0001/0", bus.gnt, bus.gnt_idx); end
        tick(4'b1111, 4'b0001, 1'b1);
        checks++;
        if (got !== expv()) begin errors++; $display("FAIL reset_release: got=%h exp=%h", got, expv()); end
        tick(4'b1111, 4'b0000, 1'b1);
        checks++;
        if (bus.gnt !== 4'b0010 || bus.gnt_idx !== 2'd1) begin errors++; $display("FAIL second_grant: gnt=%b idx=%0d exp 0010/1", bus.gnt, bus.gnt_idx); end
        tick(4'b0000, 4'b0000, 1'b1);
    endtask

    task automatic test_wrap();
        int seq[$];
        tick(4'b1001, 4'b0000, 1'b0);
        for (int c = 0; c < 6; c++) begin
            tick(4'b1001, (owner >= 0) ? N'(1) << owner : 4'b0000, 1'b1);
            checks++;
            if (got !== expv()) begin errors++; $display("FAIL wrap_cycle%0d: got=%h exp=%h", c, got, expv()); end
            if (bus.gnt_vld) seq.push_back(int'(bus.gnt_idx));
        end
        checks++;
        if (seq.size() != 3 || seq[0] != 0 || seq[1] != 3 || seq[2] != 0) begin errors++; $display("FAIL wrap_order: got=%p exp='{0,3,0}", seq); end
    endtask

    task automatic test_timeout();
        int vld_n = 0;
        int to_n = 0;
        tick(4'b0000, 4'b0000, 1'b0);
        tick(4'b0100, 4'b0000, 1'b1);
        vld_n += bus.gnt_vld;
        for (int c = 0; c < 5; c++) begin
            tick(4'b1111, 4'b0000, 1'b1);
            checks++;
            if (got !== expv()) begin errors++; $display("FAIL timeout_cycle%0d: got=%h exp=%h", c, got, expv()); end
            vld_n += bus.gnt_vld;
            if (bus.timeout) begin
                to_n++;
                checks++;
                if (bus.gnt_vld !== 1'b0) begin errors++; $display("FAIL timeout_coincide: gnt_vld=%b exp=0", bus.gnt_vld); end
                tick(4'b1111, 4'b0000, 1'b1);
                checks++;
                if (bus.gnt_idx !== 2'd3 || !bus.gnt_vld) begin errors++; $display("FAIL timeout_next: idx=%0d vld=%b exp 3/1", bus.gnt_idx, bus.gnt_vld); end
                break;
            end
        end
        checks++;
        if (vld_n != MAX_HOLD || to_n != 1) begin errors++; $display("FAIL timeout_len: vld=%0d pulses=%0d exp %0d/1", vld_n, to_n, MAX_HOLD); end
    endtask

    task automatic test_nonowner_done();
        tick(4'b0000, 4'b0000, 1'b0);
        tick(4'b0010, 4'b0000, 1'b1);
        for (int c = 0; c < 2; c++) begin
            tick(4'b0110, 4'b0100, 1'b1);
            checks++;
            if (bus.gnt !== 4'b0010 || got !== expv()) begin errors++; $display("FAIL nonowner_hold%0d: got=%h exp=%h", c, got, expv()); end
        end
        tick(4'b0100, 4'b0000, 1'b1);
        checks++;
        if (bus.gnt_vld !== 1'b0 || bus.timeout !== 1'b0) begin errors++; $display("FAIL withdraw: vld=%b to=%b exp 0/0", bus.gnt_vld, bus.timeout); end
    endtask

    task automatic test_done_timeout();
        tick(4'b0000, 4'b0000, 1'b0);
        tick(4'b0001, 4'b0000, 1'b1);
        for (int c = 0; c < 3; c++) tick(4'b0001, 4'b0000, 1'b1);
        tick(4'b0001, 4'b0001, 1'b1);
        checks++;
        if (bus.gnt_vld !== 1'b0 || bus.timeout !== 1'b0 || got !== expv()) begin errors++; $display("FAIL done_vs_timeout: got=%h exp=%h", got, expv()); end
    endtask

    task automatic test_reset_mid();
        tick(4'b0000, 4'b0000, 1'b0);
        tick(4'b1000, 4'b0000, 1'b1);
        tick(4'b1000, 4'b0000, 1'b1);
        tick(4'b1000, 4'b0000, 1'b1);
        tick(4'b1111, 4'b0000, 1'b0);
        checks++;
        if (got !== '0) begin errors++; $display("FAIL reset_mid: got=%h exp=0", got); end
        tick(4'b0100, 4'b0000, 1'b1);
        checks++;
        if (bus.gnt !== 4'b0100 || bus.gnt_idx !== 2'd2) begin errors++; $display("FAIL after_reset: gnt=%b idx=%0d exp 0100/2", bus.gnt, bus.gnt_idx); end
    endtask

    task automatic test_random();
        tick(4'b0000, 4'b0000, 1'b0);
        for (int c = 0; c < 400; c++) begin
            tick(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                 $urandom_range(0, 49) != 0);
            checks++;
            if (got !== expv()) begin errors++; $display("FAIL random_cycle%0d: got=%h exp=%h", c, got, expv()); end
        end
    endtask

    initial begin
        bus.req = '0;
        bus.done = '0;
        test_reset();
        test_wrap();
        test_timeout();
        test_nonowner_done();
        test_done_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Round-robin arbiter that shares one downstream resource between N requesters, granting one at a time and holding the grant until the owner releases it or a hold timeout expires. It sits in front of the shared datapath as its access controller. Selection uses a first-one search over a rotated request mask, so no requester starves. A grant counter limits how long one requester can monopolise the resource.

## Interface
- N, default 4: number of requesters; must be ≥ 2.
- MAX_HOLD, default 16: maximum grant length in cycles; 0 disables the timeout.
- clk  in  1  clock; everything is on the rising edge.
- rstb  in  1  reset. Reset is synchronous and active-low.
- req  in  N  request vector; bit i is requester i.
- done  in  N  release strobe; only the bit of the current owner is honoured.
- gnt  out  N  one-hot grant; all-zero when no grant is held.
- gnt_idx  out  $clog2(N)  index of the current owner; 0 when idle.
- gnt_vld  out  1  a grant is held.
- timeout  out  1  single-cycle pulse when a grant is revoked by MAX_HOLD.

## Operation
- There are two states: IDLE and BUSY.
- Reset (rstb=0 at an edge):
  - state=IDLE; gnt=0, gnt_idx=0, gnt_vld=0, timeout=0.
  - ptr=N-1, so the first search starts at index 0.
  - hold_cnt=0.
  - Reset asserted mid-grant aborts the grant at that same edge. No timeout pulse is generated.
- Selection (combinational, evaluated in IDLE):
  - masked = req & (bits with index > ptr).
  - If masked≠0, pick the lowest set index of masked. Otherwise pick the lowest set index of req.
- IDLE, req=0: stay in IDLE.
- IDLE, req≠0: go to BUSY. On that edge:
  - gnt=onehot(sel), gnt_idx=sel, gnt_vld=1.
  - ptr=sel, hold_cnt=0.
- BUSY, release: go to IDLE. Release is any of:
  - done[gnt_idx]=1;
  - req[gnt_idx]=0 (the owner withdrew its request);
  - MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1 (timeout).
- On release, gnt, gnt_idx and gnt_vld clear. timeout=1 for exactly one cycle only when the exit was caused by the timeout alone.
- If done and the timeout coincide, the exit counts as done: timeout=0.
- BUSY, no release: hold_cnt increments. It never exceeds MAX_HOLD-1.
- done bits of non-owners are ignored in every state. req changes on non-owners do not affect the current grant.
- ptr changes only when a grant is issued.
- Wrap-around: with ptr=N-1 the mask is empty, so the search starts at index 0.

## Timing
- Request to grant: 1 cycle. req sampled high at edge k gives gnt_vld=1 after edge k.
- Release to idle: done sampled at edge k clears the grant after edge k.
- Every grant is followed by at least one IDLE cycle: there is one bubble between back-to-back grants.
- Minimum grant length is 1 cycle.
- Maximum grant length is MAX_HOLD cycles when MAX_HOLD≠0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- hold_cnt width: $clog2(MAX_HOLD+1); at least 1 bit.

## Structure
- Package arb_pkg holds:
  - the state enum typedef (IDLE, BUSY);
  - a function computing the counter width from MAX_HOLD.
- Sub-module ff_lsb_encoder (parameter N): purely combational.
  - Inputs: N-bit vector.
  - Outputs: $clog2(N)-bit index of the lowest set bit, plus an any bit.
  - Instantiated twice: once on masked, once on raw req.
- The top level holds the FSM, ptr, hold_cnt and output registers.

## Test plan
All scenarios use N=4, MAX_HOLD=4.
- Reset with req=4'b1111 held. Release rstb; at the first edge the grant goes to requester 0 (gnt=0001, gnt_idx=0). Assert done[0]; after one idle cycle the next grant is gnt=0010, gnt_idx=1.
- req=4'b1001 with ptr=3 (wrap-around). The grant goes to index 0. After release the grant goes to 3, then to 0 again: the two requesters alternate.
- Grant to index 2 with done never asserted. Required response:
  - gnt_vld is high for exactly 4 cycles;
  - timeout pulses once, coincident with gnt_vld falling;
  - the next grant goes to the next higher requesting index.
- Owner 1 holds the grant while done=4'b0100 (non-owner) is asserted. The grant persists. Then req[1] drops and the grant clears with timeout=0.
- done[owner] asserted in the same cycle as hold_cnt==3. The grant clears with timeout=0.
- rstb driven low during BUSY with hold_cnt=2. At the next edge all outputs are 0 and ptr=3. After reset, req=4'b0100 gives a grant to index 2.
